// File: rtl/crc_pkg.sv
// ============================================================================
// Module   : crc_pkg
// Purpose  : Shared types and constants for the CRC check sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package crc_pkg;

  localparam int CRC_WIDTH_DEF = 16;
  localparam int DWIDTH_DEF    = 32;
  localparam int ERRCNT_W      = 16;
  // Wide enough for the largest supported timeout (255 cycles)
  localparam int TIMER_W       = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/crc_chk_timer.sv
// ============================================================================
// Module   : crc_chk_timer
// Purpose  : Loadable/clearable down-counter that flags its last counting cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_chk_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  // Asserted during the final permitted counting cycle, so the owner can act on this edge
  assign expire = dec && (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/crc_check_sequencer.sv
// ============================================================================
// Module   : crc_check_sequencer
// Purpose  : Request/response front-end that drives a single-cycle CRC stage
//            and checks its result; optional error counter via CRC_CHK_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc_check_sequencer
  import crc_pkg::*;
#(
  parameter int CRC_WIDTH   = CRC_WIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [DWIDTH-1:0]    reqData,
  input  logic [CRC_WIDTH-1:0] reqExpCrc,
  output logic                 crcCtrlEn,
  output logic [DWIDTH-1:0]    crcDataIn,
  input  logic [CRC_WIDTH-1:0] crcOut,
  input  logic                 crcReady,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [CRC_WIDTH-1:0] rspCrc,
  output logic                 rspMatch,
  output logic                 rspTimeout,
  output logic [ERRCNT_W-1:0]  errCount
);

  seq_state_t           state;
  seq_state_t           state_nxt;
  logic [CRC_WIDTH-1:0] exp_crc;
  logic                 waiting;
  logic                 tmr_expire;
  logic                 done_ok;
  logic                 abort;

  assign waiting = (state == WAIT_LOW) || (state == WAIT_HIGH);
  // A result arriving in the last allowed cycle still counts as a normal completion
  assign done_ok = (state == WAIT_HIGH) && crcReady;
  assign abort   = waiting && tmr_expire && !done_ok;

  crc_chk_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == IDLE),
    .load     (state == ISSUE),
    .dec      (waiting),
    .load_val (TIMER_W'(TIMEOUT_CYC)),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (reqValid) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (abort)          state_nxt = RESP;
        else if (!crcReady) state_nxt = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (done_ok || abort) state_nxt = RESP;
      end
      RESP: begin
        if (rspReady) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign reqReady  = (state == IDLE);
  assign crcCtrlEn = (state == ISSUE);
  assign rspValid  = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crcDataIn  <= '0;
      exp_crc    <= '0;
      rspCrc     <= '0;
      rspMatch   <= 1'b0;
      rspTimeout <= 1'b0;
    end else begin
      if ((state == IDLE) && reqValid) begin
        crcDataIn <= reqData;
        exp_crc   <= reqExpCrc;
      end
      if (done_ok) begin
        rspCrc     <= crcOut;
        rspMatch   <= (crcOut == exp_crc);
        rspTimeout <= 1'b0;
      end else if (abort) begin
        rspCrc     <= '0;
        rspMatch   <= 1'b0;
        rspTimeout <= 1'b1;
      end
    end
  end

`ifdef CRC_CHK_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt;
  logic                rsp_bad;

  assign rsp_bad = (done_ok && (crcOut != exp_crc)) || abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (rsp_bad && (err_cnt != {ERRCNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  assign errCount = err_cnt;
`else
  assign errCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_crc_check_sequencer.sv
// ============================================================================
// Module   : tb_crc_check_sequencer
// Purpose  : Scoreboard bench for crc_check_sequencer with a CRC-16/0x1021 stage model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_crc_check_sequencer;

  localparam int CW = 16;
  localparam int DW = 32;
  localparam int TO = 15;
`ifdef CRC_CHK_ERRCNT_EN
  localparam bit ERRCNT_ON = 1'b1;
`else
  localparam bit ERRCNT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [DW-1:0] reqData = '0;
  logic [CW-1:0] reqExpCrc = '0;
  logic          crcCtrlEn;
  logic [DW-1:0] crcDataIn;
  logic [CW-1:0] crcOut;
  logic          crcReady;
  logic          rspValid;
  logic          rspReady = 1'b1;
  logic [CW-1:0] rspCrc;
  logic          rspMatch;
  logic          rspTimeout;
  logic [15:0]   errCount;

  crc_check_sequencer #(
    .CRC_WIDTH   (CW),
    .DWIDTH      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqData    (reqData),
    .reqExpCrc  (reqExpCrc),
    .crcCtrlEn  (crcCtrlEn),
    .crcDataIn  (crcDataIn),
    .crcOut     (crcOut),
    .crcReady   (crcReady),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .rspCrc     (rspCrc),
    .rspMatch   (rspMatch),
    .rspTimeout (rspTimeout),
    .errCount   (errCount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CRC-16, poly 0x1021, init 0, MSB first, no reflection, no final XOR
  function automatic logic [15:0] crc16_ref(input logic [31:0] d);
    logic [15:0] c;
    logic        fb;
    c = '0;
    for (int i = 31; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  // Single-cycle CRC stage: ready drops for the cycle after enable, result valid when it returns
  logic          stage_rdy = 1'b1;
  logic [CW-1:0] stage_out = '0;
  bit            stuck = 1'b0;

  always @(posedge clk) begin
    if (crcCtrlEn) begin
      stage_rdy <= 1'b0;
      stage_out <= crc16_ref(crcDataIn);
    end else begin
      stage_rdy <= 1'b1;
    end
  end

  assign crcReady = stuck ? 1'b1 : stage_rdy;
  assign crcOut   = stage_out;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          acc;
    logic [15:0] crc;
    logic        match;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  int          acc_q[$];
  exp_t        e_pop;
  exp_t        e_new;
  int          rsp_cnt  = 0;
  int          xfer_cyc = 0;
  int          err_model = 0;
  int          en_cnt = 0;
  bit          prev_rv = 1'b0;
  bit          held_ok = 1'b0;
  logic [15:0] held_crc;
  logic        held_match;
  logic        held_to;
  logic [15:0] last_crc;
  logic        last_match;
  logic        last_to;
  int          last_lat = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_rv = 1'b0;
      held_ok = 1'b0;
      en_cnt  = 0;
    end else begin
      if (crcCtrlEn) en_cnt++;
      if (rspValid) check("req_ready_in_resp", 32'(reqReady), 32'd0);
      if (rspValid && !prev_rv) begin
        if (sb.size() > 0) begin
          last_lat = cyc - sb[0].acc;
          check("latency", 32'(last_lat), sb[0].to ? 32'(TO + 1) : 32'd3);
        end else begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end
      end
      if (rspValid && held_ok) begin
        check("hold_crc", 32'(rspCrc), 32'(held_crc));
        check("hold_match", 32'(rspMatch), 32'(held_match));
        check("hold_timeout", 32'(rspTimeout), 32'(held_to));
      end
      if (rspValid) begin
        held_crc   = rspCrc;
        held_match = rspMatch;
        held_to    = rspTimeout;
        held_ok    = 1'b1;
      end
      if (rspValid && rspReady) begin
        held_ok  = 1'b0;
        xfer_cyc = cyc + 1;
        if (sb.size() > 0) begin
          e_pop = sb.pop_front();
          check("rsp_crc", 32'(rspCrc), 32'(e_pop.crc));
          check("rsp_match", 32'(rspMatch), 32'(e_pop.match));
          check("rsp_timeout", 32'(rspTimeout), 32'(e_pop.to));
          if (!e_pop.match && err_model < 65535) err_model++;
          check("err_count", 32'(errCount), ERRCNT_ON ? 32'(err_model) : 32'd0);
        end else begin
          check("rsp_no_expect", 32'd1, 32'd0);
        end
        check("en_pulse_count", 32'(en_cnt), 32'd1);
        en_cnt     = 0;
        last_crc   = rspCrc;
        last_match = rspMatch;
        last_to    = rspTimeout;
        rsp_cnt++;
      end
      if (reqValid && reqReady) begin
        e_new.acc   = cyc + 1;
        e_new.to    = stuck;
        e_new.crc   = stuck ? 16'h0000 : crc16_ref(reqData);
        e_new.match = !stuck && (crc16_ref(reqData) == reqExpCrc);
        sb.push_back(e_new);
        acc_q.push_back(cyc + 1);
      end
      prev_rv = rspValid;
    end
  end

  task automatic send(input logic [31:0] d, input logic [15:0] e);
    @(posedge clk);
    #1;
    reqValid  = 1'b1;
    reqData   = d;
    reqExpCrc = e;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (reqReady) break;
    end
    if (!reqReady) check("send_accept_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_rsps(input int target);
    for (int i = 0; i < 300; i++) begin
      if (rsp_cnt >= target) break;
      @(negedge clk);
    end
    check("rsp_wait_bound", 32'(rsp_cnt >= target), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  int          base;
  bit          saw_rv;
  logic [31:0] d6;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(reqReady), 32'd1);
    check("rst_ctrl_en", 32'(crcCtrlEn), 32'd0);
    check("rst_data_in", crcDataIn, 32'd0);
    check("rst_rsp_valid", 32'(rspValid), 32'd0);
    check("rst_rsp_crc", 32'(rspCrc), 32'd0);
    check("rst_rsp_match", 32'(rspMatch), 32'd0);
    check("rst_rsp_timeout", 32'(rspTimeout), 32'd0);
    check("rst_err_count", 32'(errCount), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known vector: x^16 mod P is the polynomial itself
    send(32'h0000_0001, 16'h1021);
    wait_rsps(1);
    check("t2_crc", 32'(last_crc), 32'h1021);
    check("t2_match", 32'(last_match), 32'd1);
    check("t2_timeout", 32'(last_to), 32'd0);
    check("t2_latency", 32'(last_lat), 32'd3);

    send(32'h0000_0000, 16'h1234);
    wait_rsps(2);
    check("t3_crc", 32'(last_crc), 32'h0000);
    check("t3_match", 32'(last_match), 32'd0);
    check("t3_err_count", 32'(errCount), ERRCNT_ON ? 32'd1 : 32'd0);

    // Reset while waiting for the stage's ready to return
    send(32'hDEAD_BEEF, 16'h0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    err_model = 0;
    check("t1_req_ready", 32'(reqReady), 32'd1);
    check("t1_ctrl_en", 32'(crcCtrlEn), 32'd0);
    check("t1_data_in", crcDataIn, 32'd0);
    check("t1_rsp_valid", 32'(rspValid), 32'd0);
    check("t1_rsp_crc", 32'(rspCrc), 32'd0);
    check("t1_rsp_match", 32'(rspMatch), 32'd0);
    check("t1_err_count", 32'(errCount), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_rv = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rspValid) saw_rv = 1'b1;
    end
    check("t1_no_rsp_after_rst", 32'(saw_rv), 32'd0);
    send(32'h1234_5678, crc16_ref(32'h1234_5678));
    wait_rsps(3);
    check("t1_next_match", 32'(last_match), 32'd1);

    // Stage never drops ready
    stuck = 1'b1;
    send(32'hCAFE_F00D, 16'h0000);
    wait_rsps(4);
    stuck = 1'b0;
    check("t4_timeout", 32'(last_to), 32'd1);
    check("t4_match", 32'(last_match), 32'd0);
    check("t4_crc", 32'(last_crc), 32'd0);
    check("t4_latency", 32'(last_lat), 32'(TO + 1));
    check("t4_err_count", 32'(errCount), ERRCNT_ON ? 32'd1 : 32'd0);

    // Back-pressured response with a queued request
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    send(32'h0000_00A5, 16'hFFFF);
    for (int i = 0; i < 20; i++) begin
      if (rspValid) break;
      @(negedge clk);
    end
    check("t5_rsp_seen", 32'(rspValid), 32'd1);
    @(posedge clk);
    #1;
    reqValid  = 1'b1;
    reqData   = 32'h8000_0000;
    reqExpCrc = crc16_ref(32'h8000_0000);
    acc_q.delete();
    repeat (10) begin
      @(negedge clk);
      check("t5_req_ready_low", 32'(reqReady), 32'd0);
    end
    @(posedge clk);
    #1;
    rspReady = 1'b1;
    wait_rsps(5);
    for (int i = 0; i < 10; i++) begin
      if (acc_q.size() > 0) break;
      @(negedge clk);
    end
    check("t5_accept_seen", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) check("t5_accept_gap", 32'(acc_q[0] - xfer_cyc), 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    wait_rsps(6);
    check("t5_second_match", 32'(last_match), 32'd1);

    // Back-to-back requests
    acc_q.delete();
    base = rsp_cnt;
    for (int k = 0; k < 4; k++) begin
      d6 = $urandom;
      send(d6, (k % 2 == 0) ? crc16_ref(d6) : ~crc16_ref(d6));
    end
    wait_rsps(base + 4);
    check("t6_accepts", 32'(acc_q.size()), 32'd4);
    for (int k = 1; k < 4; k++) begin
      if (acc_q.size() > k) check("t6_gap", 32'(acc_q[k] - acc_q[k-1]), 32'd5);
    end
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
